fetch_sequencer: RTL and testbench

//  Fetch/execute control FSM that drives the 12-bit program counter (enable/load)
//  and the instruction register of the processor. Reads bytes from the program ROM

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its PC / ROM / ALU neighbours.
// The sequencer uses the slave modport; the surrounding datapath uses master.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 12
);
  // Handshake: exec_valid is a one-cycle strobe with no back-pressure; instr is
  // stable while it is high, and pc_en/pc_load take effect on the next clk edge.
  logic              run;
  logic [ADDR_W-1:0] pc_value;
  logic [7:0]        rom_data;
  logic              flag_c;
  logic              flag_z;
  logic              pc_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_data;
  logic [7:0]        instr;
  logic              exec_valid;
  logic              halted;
  logic              stack_err;

  modport master (
    output run, pc_value, rom_data, flag_c, flag_z,
    input  pc_en, pc_load, pc_load_data, instr, exec_valid, halted, stack_err
  );

  modport slave (
    input  run, pc_value, rom_data, flag_c, flag_z,
    output pc_en, pc_load, pc_load_data, instr, exec_valid, halted, stack_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/execute control FSM driving PC enable/load and the instruction register.
// Optional return-address stack for CALL/RET is enabled with `define CALL_STACK_EN.
module fetch_sequencer #(
  parameter int         ADDR_W  = 12,
  parameter logic [3:0] OP_HALT = 4'h1,
  parameter logic [3:0] OP_JC   = 4'hD,
  parameter logic [3:0] OP_JZ   = 4'hE,
  parameter logic [3:0] OP_JMP  = 4'hF
`ifdef CALL_STACK_EN
  ,
  parameter logic [3:0] OP_CALL     = 4'hC,
  parameter logic [3:0] OP_RET      = 4'hB,
  parameter int         STACK_DEPTH = 4
`endif
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.slave    bus,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [3:0]        op_w;
  logic              two_byte_w;

  assign op_w = instr_q[7:4];

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, top_w;
  logic              err_q, err_d, push_en;

  assign top_w         = sp_q - 1'b1;
  assign bus.stack_err = err_q;
  assign two_byte_w    = (bus.rom_data[7:4] == OP_JMP) || (bus.rom_data[7:4] == OP_JZ) ||
                         (bus.rom_data[7:4] == OP_JC)  || (bus.rom_data[7:4] == OP_CALL);
`else
  logic unused_pc_value;

  assign unused_pc_value = ^bus.pc_value;
  assign bus.stack_err   = 1'b0;
  assign two_byte_w      = (bus.rom_data[7:4] == OP_JMP) || (bus.rom_data[7:4] == OP_JZ) ||
                           (bus.rom_data[7:4] == OP_JC);
`endif

  always_comb begin
    state_d          = state_q;
    instr_d          = instr_q;
    target_d         = target_q;
    bus.pc_en        = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_load_data = '0;
    bus.exec_valid   = 1'b0;
    bus.halted       = 1'b0;
`ifdef CALL_STACK_EN
    sp_d             = sp_q;
    err_d            = err_q;
    push_en          = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.pc_en = 1'b1;
        instr_d   = bus.rom_data;
        state_d   = two_byte_w ? S_FETCH2 : S_EXEC;
      end
      S_FETCH2: begin
        bus.pc_en = 1'b1;
        target_d  = ADDR_W'({instr_q[3:0], bus.rom_data});
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        bus.exec_valid = 1'b1;
        if ((op_w == OP_JMP) || ((op_w == OP_JZ) && bus.flag_z) ||
            ((op_w == OP_JC) && bus.flag_c)) begin
          bus.pc_load      = 1'b1;
          bus.pc_load_data = target_q;
        end
`ifdef CALL_STACK_EN
        // A call on a full stack still jumps; only the return address is lost.
        else if (op_w == OP_CALL) begin
          bus.pc_load      = 1'b1;
          bus.pc_load_data = target_q;
          if (sp_q != SP_FULL) begin
            push_en = 1'b1;
            sp_d    = sp_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (op_w == OP_RET) begin
          if (sp_q != '0) begin
            bus.pc_load      = 1'b1;
            bus.pc_load_data = stack_q[top_w[IDX_W-1:0]];
            sp_d             = top_w;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        if (op_w == OP_HALT) state_d = S_HALT;
        else if (bus.run)    state_d = S_FETCH;
        else                 state_d = S_IDLE;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= 8'h00;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      target_q <= target_d;
    end
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return address is the PC after both call bytes, already on pc_value in EXEC.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q[IDX_W-1:0]] <= bus.pc_value;
  end
`endif

  assign bus.instr = instr_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: an instruction-level model of the ROM
// program predicts each executed instruction, its successor PC and its latency.
module tb_fetch_sequencer;
  localparam int AW = 12;
  localparam int W  = 22;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(AW)) bus ();
  logic [2:0] state_dbg;

  fetch_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_dbg)
  );

  logic [7:0]    rom [4096];
  logic [AW-1:0] pc;

  assign bus.pc_value = pc;
  assign bus.rom_data = rom[pc];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            pc <= '0;
    else if (bus.pc_load) pc <= bus.pc_load_data;
    else if (bus.pc_en)   pc <= pc + 12'd1;
  end

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q [$];
  logic         mon_en = 1'b0;
  int           pen_cnt = 0;
  logic [W-1:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every exec strobe.
  always @(negedge clk) begin
    if (reset) begin
      pen_cnt = 0;
    end else begin
      check("en_with_load", 32'(bus.pc_en & bus.pc_load), 0);
      if (!bus.pc_load) check("load_data_idle", 32'(bus.pc_load_data), 0);
      if (bus.exec_valid) begin
        if (mon_en && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("instr", 32'(bus.instr), 32'(e[21:14]));
          check("next_pc", 32'(bus.pc_load ? bus.pc_load_data : pc), 32'(e[13:2]));
          check("latency", pen_cnt + 1, 32'(e[1:0]));
        end
        pen_cnt = 0;
      end else if (bus.pc_en) begin
        pen_cnt++;
      end
    end
  end

  task automatic fill_rom(input bit rnd);
    for (int i = 0; i < 4096; i++) begin
      if (rnd) begin
        rom[i] = 8'($urandom_range(0, 255));
        if (rom[i][7:4] == 4'h1 && $urandom_range(0, 7) != 0) rom[i][7:4] = 4'h2;
      end else begin
        rom[i] = 8'h00;
      end
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.run = 1'b0;
    mon_en  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_pc_en", 32'(bus.pc_en), 0);
    check("rst_pc_load", 32'(bus.pc_load), 0);
    check("rst_load_data", 32'(bus.pc_load_data), 0);
    check("rst_exec_valid", 32'(bus.exec_valid), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_instr", 32'(bus.instr), 0);
    check("rst_stack_err", 32'(bus.stack_err), 0);
    check("rst_state_idle", 32'(state_dbg), 0);
    reset = 1'b0;
  endtask

  // Instruction-level interpreter of the ROM program from address 0.
  task automatic model_program(input int nmax, input logic fz, input logic fc,
                               output logic exp_halt, output logic exp_err);
    logic [AW-1:0] p, p1, after, nxt, tgt;
    logic [AW-1:0] ret_q [$];
    logic [7:0]    b;
    logic [3:0]    op;
    logic [1:0]    lat;
    bit            two;
    p = '0;
    exp_halt = 1'b0;
    exp_err  = 1'b0;
    for (int i = 0; i < nmax; i++) begin
      b   = rom[p];
      op  = b[7:4];
      p1  = p + 12'd1;
      two = (op == 4'hD) || (op == 4'hE) || (op == 4'hF);
`ifdef CALL_STACK_EN
      two = two || (op == 4'hC);
`endif
      if (two) begin
        tgt   = {b[3:0], rom[p1]};
        after = p + 12'd2;
        lat   = 2'd3;
      end else begin
        tgt   = '0;
        after = p1;
        lat   = 2'd2;
      end
      nxt = after;
      case (op)
        4'hF: nxt = tgt;
        4'hE: if (fz) nxt = tgt;
        4'hD: if (fc) nxt = tgt;
`ifdef CALL_STACK_EN
        4'hC: begin
          if (ret_q.size() < 4) ret_q.push_back(after);
          else exp_err = 1'b1;
          nxt = tgt;
        end
        4'hB: begin
          if (ret_q.size() > 0) nxt = ret_q.pop_back();
          else exp_err = 1'b1;
        end
`endif
        default: ;
      endcase
      exp_q.push_back({b, nxt, lat});
      if (op == 4'h1) begin
        exp_halt = 1'b1;
        break;
      end
      p = nxt;
    end
  endtask

  task automatic run_program(input string name, input int nmax, input logic fz, input logic fc);
    logic eh, ee;
    int   t;
    do_reset();
    bus.flag_z = fz;
    bus.flag_c = fc;
    model_program(nmax, fz, fc, eh, ee);
    mon_en  = 1'b1;
    bus.run = 1'b1;
    t = 0;
    while (exp_q.size() > 0 && t < 4 * nmax + 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    #1;
    check({name, "_halted"}, 32'(bus.halted), 32'(eh));
`ifdef CALL_STACK_EN
    check({name, "_stack_err"}, 32'(bus.stack_err), 32'(ee));
`else
    check({name, "_stack_err"}, 32'(bus.stack_err), 0);
    if (ee) $display("note: unexpected model stack error");
`endif
    bus.run = 1'b0;
    mon_en  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.run    = 1'b0;
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;

    // single-byte instruction
    fill_rom(0);
    rom[0] = 8'h27;
    run_program("one_byte", 1, 1'b0, 1'b0);

    // unconditional jump, then a distinguishable byte at the target
    fill_rom(0);
    rom[0] = 8'hF3; rom[1] = 8'h45; rom[12'h345] = 8'h5A;
    run_program("jmp", 2, 1'b0, 1'b0);

    // JZ untaken and taken
    fill_rom(0);
    rom[0] = 8'hE0; rom[1] = 8'h80; rom[2] = 8'h33; rom[12'h80] = 8'h44;
    run_program("jz_untaken", 2, 1'b0, 1'b1);
    run_program("jz_taken", 2, 1'b1, 1'b0);

    // JC taken with flag_c
    fill_rom(0);
    rom[0] = 8'hD7; rom[1] = 8'h21; rom[12'h721] = 8'h66;
    run_program("jc_taken", 2, 1'b0, 1'b1);

    // HALT then run toggling must not wake it
    fill_rom(0);
    rom[0] = 8'h10;
    run_program("halt", 5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.run = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_pc_en", 32'(bus.pc_en), 0);
      check("halt_pc_load", 32'(bus.pc_load), 0);
      check("halt_exec", 32'(bus.exec_valid), 0);
      check("halt_halted", 32'(bus.halted), 1);
    end
    do_reset();

    // reset asserted while the second jump byte is being fetched
    fill_rom(0);
    rom[0] = 8'hF3; rom[1] = 8'h45;
    do_reset();
    bus.run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("fetch2_pc_en", 32'(bus.pc_en), 1);
    reset = 1'b1;
    #1;
    check("midrst_pc_en", 32'(bus.pc_en), 0);
    check("midrst_pc_load", 32'(bus.pc_load), 0);
    check("midrst_exec", 32'(bus.exec_valid), 0);
    check("midrst_instr", 32'(bus.instr), 0);
    check("midrst_state", 32'(state_dbg), 0);
    @(negedge clk);
    check("midrst_hold_pc_en", 32'(bus.pc_en), 0);
    do_reset();

`ifdef CALL_STACK_EN
    // call/return, return on empty stack, then five nested calls
    fill_rom(0);
    rom[0] = 8'hF0; rom[1] = 8'h10;
    rom[12'h010] = 8'hC1; rom[12'h011] = 8'h00;
    rom[12'h100] = 8'hB0;
    rom[12'h012] = 8'hB0;
    rom[12'h013] = 8'hF2; rom[12'h014] = 8'h00;
    for (int k = 0; k < 5; k++) begin
      rom[12'h200 + 12'(k * 16)] = 8'hC2;
      rom[12'h201 + 12'(k * 16)] = 8'(8'h10 + k * 16);
    end
    rom[12'h250] = 8'h10;
    run_program("call_stack", 20, 1'b0, 1'b0);
`else
    // CALL/RET opcodes are plain single-byte instructions here
    fill_rom(0);
    rom[0] = 8'hC1; rom[1] = 8'hB0; rom[2] = 8'h00;
    run_program("call_plain", 3, 1'b0, 1'b0);
`endif

    // randomized programs over a random ROM image
    for (int n = 0; n < 25; n++) begin
      fill_rom(1);
      run_program("random", 40, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
